// File: rtl/c2f_chunk_receiver.sv
// C2F chunk receiver: buffers host-written chunk slots, streams published QWs in
// order, and posts the drained read pointer back to host memory. Optional build macro: C2F_RCV_CHECKSUM_EN.
`timescale 1ns/1ps
module c2f_chunk_receiver #(
    parameter int unsigned NUM_CHUNKS = 4,
    parameter int unsigned CHUNK_QWS  = 512,
    localparam int unsigned CI_W      = $clog2(NUM_CHUNKS),
    localparam int unsigned QW_W      = $clog2(CHUNK_QWS),
    localparam int unsigned AW        = CI_W + QW_W
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            ramWrEnable_in,
    input  logic [AW-1:0]   ramWrAddr_in,
    input  logic [63:0]     ramWrData_in,
    input  logic            wrPtrValid_in,
    input  logic [CI_W-1:0] wrPtr_in,
    input  logic [60:0]     mtrBase_in,
    output logic [63:0]     rdData_out,
    output logic            rdValid_out,
    input  logic            rdReady_in,
    output logic            ptrReq_out,
    output logic [61:0]     ptrDwAddr_out,
    output logic [31:0]     ptrData_out,
    input  logic            ptrAck_in,
    output logic [CI_W-1:0] level_out,
    output logic [63:0]     checksum_out
);

    localparam int unsigned DEPTH = NUM_CHUNKS * CHUNK_QWS;

    typedef enum logic {ST_IDLE, ST_REQ} ptr_state_t;

    logic [63:0]     mem [DEPTH];
    logic [CI_W-1:0] wr_ptr, rd_ptr, fch_ptr;
    logic [CI_W-1:0] wr_ptr_nxt, rd_ptr_nxt;
    logic [QW_W-1:0] qw_idx;
    logic [63:0]     skid_data, fetch_data;
    logic            skid_valid, skid_last, out_last;
    logic            pop, room, fetch, fetch_last, drain;
    logic            ptr_pending;
    ptr_state_t      state;

    // Host writes are never gated
    always_ff @(posedge clk_in) begin
        if (ramWrEnable_in) begin
            mem[ramWrAddr_in] <= ramWrData_in;
        end
    end

    // Fetch runs on its own chunk pointer so it can prefetch into the next
    // chunk before the final QW of the current one is accepted.
    assign pop        = rdValid_out & rdReady_in;
    assign room       = !(rdValid_out && skid_valid && !pop);
    assign fetch      = room && (fch_ptr != wr_ptr);
    assign fetch_last = (qw_idx == QW_W'(CHUNK_QWS - 1));
    assign fetch_data = mem[{fch_ptr, qw_idx}];
    assign drain      = pop & out_last;
    assign wr_ptr_nxt = wrPtrValid_in ? wrPtr_in : wr_ptr;
    assign rd_ptr_nxt = drain ? rd_ptr + CI_W'(1) : rd_ptr;

    // Queue pointers, fetch counter and fill level
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fch_ptr   <= '0;
            qw_idx    <= '0;
            level_out <= '0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            level_out <= wr_ptr_nxt - rd_ptr_nxt;
            if (fetch) begin
                qw_idx <= qw_idx + QW_W'(1);
                if (fetch_last) begin
                    fch_ptr <= fch_ptr + CI_W'(1);
                end
            end
        end
    end

    // Two-entry output FIFO: output register plus skid; RAM read lands directly in it
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            rdValid_out <= 1'b0;
            rdData_out  <= '0;
            out_last    <= 1'b0;
            skid_valid  <= 1'b0;
            skid_data   <= '0;
            skid_last   <= 1'b0;
        end else if (pop || !rdValid_out) begin
            if (skid_valid) begin
                rdValid_out <= 1'b1;
                rdData_out  <= skid_data;
                out_last    <= skid_last;
                skid_valid  <= fetch;
                if (fetch) begin
                    skid_data <= fetch_data;
                    skid_last <= fetch_last;
                end
            end else begin
                rdValid_out <= fetch;
                if (fetch) begin
                    rdData_out <= fetch_data;
                    out_last   <= fetch_last;
                end
            end
        end else if (fetch) begin
            skid_valid <= 1'b1;
            skid_data  <= fetch_data;
            skid_last  <= fetch_last;
        end
    end

    // Read-pointer writeback; drains during REQ coalesce into one re-issue
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state         <= ST_IDLE;
            ptr_pending   <= 1'b0;
            ptrReq_out    <= 1'b0;
            ptrData_out   <= '0;
            ptrDwAddr_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ptr_pending) begin
                        state         <= ST_REQ;
                        ptrReq_out    <= 1'b1;
                        ptrData_out   <= 32'(rd_ptr);
                        ptrDwAddr_out <= {mtrBase_in, 1'b1};
                    end
                end
                ST_REQ: begin
                    if (ptrAck_in) begin
                        state      <= ST_IDLE;
                        ptrReq_out <= 1'b0;
                    end
                end
            endcase
            if (drain) begin
                ptr_pending <= 1'b1;
            end else if (state == ST_IDLE) begin
                ptr_pending <= 1'b0;
            end
        end
    end

`ifdef C2F_RCV_CHECKSUM_EN
    // Running sum of every accepted QW
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            checksum_out <= '0;
        end else if (pop) begin
            checksum_out <= checksum_out + rdData_out;
        end
    end
`else
    assign checksum_out = '0;
`endif

endmodule

// File: tb/tb_c2f_chunk_receiver.sv
// Directed bench for c2f_chunk_receiver with NUM_CHUNKS=4, CHUNK_QWS=8.
`timescale 1ns/1ps
module tb_c2f_chunk_receiver;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        ram_wr_en;
    logic [4:0]  ram_wr_addr;
    logic [63:0] ram_wr_data;
    logic        wr_ptr_valid;
    logic [1:0]  wr_ptr;
    logic [60:0] mtr_base;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        ptr_req;
    logic [61:0] ptr_dw_addr;
    logic [31:0] ptr_data;
    logic        ptr_ack;
    logic [1:0]  level;
    logic [63:0] checksum;

    int n_chk  = 0;
    int n_pass = 0;
    logic [63:0] exp_q[$];

`ifdef C2F_RCV_CHECKSUM_EN
    localparam logic [63:0] CK_EXP = 64'h2;
`else
    localparam logic [63:0] CK_EXP = 64'h0;
`endif

    c2f_chunk_receiver #(.NUM_CHUNKS(4), .CHUNK_QWS(8)) dut (
        .clk_in(clk), .reset_in(reset_in),
        .ramWrEnable_in(ram_wr_en), .ramWrAddr_in(ram_wr_addr), .ramWrData_in(ram_wr_data),
        .wrPtrValid_in(wr_ptr_valid), .wrPtr_in(wr_ptr), .mtrBase_in(mtr_base),
        .rdData_out(rd_data), .rdValid_out(rd_valid), .rdReady_in(rd_ready),
        .ptrReq_out(ptr_req), .ptrDwAddr_out(ptr_dw_addr), .ptrData_out(ptr_data),
        .ptrAck_in(ptr_ack), .level_out(level), .checksum_out(checksum)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push_chunk(input logic [1:0] chunk, input logic [63:0] base);
        for (int i = 0; i < 8; i++) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = {chunk, 3'(i)};
            ram_wr_data = base + 64'(i);
            exp_q.push_back(base + 64'(i));
            step();
        end
        ram_wr_en = 1'b0;
    endtask

    task automatic publish(input logic [1:0] p);
        wr_ptr_valid = 1'b1;
        wr_ptr       = p;
        step();
        wr_ptr_valid = 1'b0;
    endtask

    task automatic drain(input int n, input int budget, input bit toggle);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < budget) begin
            if (toggle) rd_ready = ~rd_ready;
            if (rd_valid && rd_ready) begin
                chk("stream_data", rd_data, exp_q.pop_front());
                got++;
            end
            step();
            cyc++;
        end
        chk("drain_count", 64'(got), 64'(n));
    endtask

    initial begin
        int reqs;
        logic [63:0] ck_vec [8];
        reset_in = 1'b1; ram_wr_en = 1'b0; ram_wr_addr = '0; ram_wr_data = '0;
        wr_ptr_valid = 1'b0; wr_ptr = '0; rd_ready = 1'b0; ptr_ack = 1'b0;
        mtr_base = 61'h0123_4567_89AB_CDEF;
        step(); step();
        reset_in = 1'b0;

        // reset values
        chk("rst_rd_valid", 64'(rd_valid), 64'h0);
        chk("rst_rd_data", rd_data, 64'h0);
        chk("rst_ptr_req", 64'(ptr_req), 64'h0);
        chk("rst_ptr_data", 64'(ptr_data), 64'h0);
        chk("rst_level", 64'(level), 64'h0);
        chk("rst_checksum", checksum, 64'h0);

        // single chunk: latency, back-to-back data, pointer post
        push_chunk(2'd0, 64'd1);
        rd_ready = 1'b1;
        publish(2'd1);
        chk("t1_valid_n1", 64'(rd_valid), 64'h0);
        chk("t1_level_n1", 64'(level), 64'h1);
        step();
        for (int k = 0; k < 8; k++) begin
            chk("t1_valid_seq", 64'(rd_valid), 64'h1);
            chk("t1_data_seq", rd_data, exp_q.pop_front());
            step();
        end
        chk("t1_valid_end", 64'(rd_valid), 64'h0);
        chk("t1_level_end", 64'(level), 64'h0);
        chk("t1_req_early", 64'(ptr_req), 64'h0);
        step();
        chk("t1_req", 64'(ptr_req), 64'h1);
        chk("t1_ptr_data", 64'(ptr_data), 64'h1);
        chk("t1_dw_addr", 64'(ptr_dw_addr), 64'h2468_ACF1_3579_BDF);
        ptr_ack = 1'b1;
        step();
        chk("t1_req_drop", 64'(ptr_req), 64'h0);

        // backpressure: ready toggles every cycle
        rd_ready = 1'b0;
        push_chunk(2'd1, 64'd100);
        publish(2'd2);
        drain(8, 60, 1'b1);
        rd_ready = 1'b1;
        step(); step(); step(); step();
        chk("t2_ptr_data", 64'(ptr_data), 64'h2);
        chk("t2_level", 64'(level), 64'h0);

        // wrap: three chunks outstanding, then one more past the wrap
        rd_ready = 1'b0;
        push_chunk(2'd2, 64'd200);
        push_chunk(2'd3, 64'd300);
        push_chunk(2'd0, 64'd400);
        publish(2'd1);
        chk("t3_level_peak", 64'(level), 64'h3);
        rd_ready = 1'b1;
        drain(24, 100, 1'b0);
        push_chunk(2'd1, 64'd500);
        publish(2'd2);
        drain(8, 40, 1'b0);
        step(); step(); step(); step();
        chk("t3_level", 64'(level), 64'h0);
        chk("t3_ptr_data", 64'(ptr_data), 64'h2);

        // coalescing: two drains while the first request is unacknowledged
        ptr_ack  = 1'b0;
        rd_ready = 1'b0;
        push_chunk(2'd2, 64'd600);
        push_chunk(2'd3, 64'd700);
        rd_ready = 1'b1;
        publish(2'd0);
        drain(16, 60, 1'b0);
        step(); step(); step();
        chk("t4_req_held", 64'(ptr_req), 64'h1);
        chk("t4_first_data", 64'(ptr_data), 64'h3);
        ptr_ack = 1'b1;
        step();
        ptr_ack = 1'b0;
        chk("t4_req_gap", 64'(ptr_req), 64'h0);
        step();
        chk("t4_reissue", 64'(ptr_req), 64'h1);
        chk("t4_reissue_data", 64'(ptr_data), 64'h0);
        ptr_ack = 1'b1;
        step();
        ptr_ack = 1'b0;
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            if (ptr_req) reqs++;
            step();
        end
        chk("t4_no_extra_req", 64'(reqs), 64'h0);

        // reset at QW 4 of a chunk while a request is outstanding
        rd_ready = 1'b0;
        push_chunk(2'd0, 64'd800);
        push_chunk(2'd1, 64'd900);
        rd_ready = 1'b1;
        publish(2'd2);
        drain(12, 60, 1'b0);
        chk("t5_qw4_data", rd_data, 64'd904);
        chk("t5_req_before", 64'(ptr_req), 64'h1);
        reset_in = 1'b1;
        step();
        reset_in = 1'b0;
        chk("t5_rst_valid", 64'(rd_valid), 64'h0);
        chk("t5_rst_data", rd_data, 64'h0);
        chk("t5_rst_req", 64'(ptr_req), 64'h0);
        chk("t5_rst_ptr_data", 64'(ptr_data), 64'h0);
        chk("t5_rst_level", 64'(level), 64'h0);
        chk("t5_rst_checksum", checksum, 64'h0);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(64'd800 + 64'(i));
        publish(2'd1);
        chk("t5_valid_n1", 64'(rd_valid), 64'h0);
        step();
        chk("t5_valid_n2", 64'(rd_valid), 64'h1);
        chk("t5_data_n2", rd_data, 64'd800);
        drain(8, 30, 1'b0);
        step(); step(); step();
        chk("t5_req", 64'(ptr_req), 64'h1);
        chk("t5_ptr_data", 64'(ptr_data), 64'h1);
        ptr_ack = 1'b1;
        step();
        ptr_ack = 1'b0;

        // checksum wraps modulo 2^64 (stays zero when not built)
        reset_in = 1'b1;
        step();
        reset_in = 1'b0;
        ck_vec = '{64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
        for (int i = 0; i < 8; i++) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = {2'd0, 3'(i)};
            ram_wr_data = ck_vec[i];
            exp_q.push_back(ck_vec[i]);
            step();
        end
        ram_wr_en = 1'b0;
        rd_ready  = 1'b1;
        publish(2'd1);
        drain(8, 30, 1'b0);
        step();
        chk("t6_checksum", checksum, CK_EXP);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
